// File: rtl/types.sv
// Shared NoC types: flit layout, error signals, and the flit checksum.
package types;

  localparam int FLIT_WIDTH = 128;
  localparam int FLIT_BYTES = FLIT_WIDTH / 8;

  typedef logic [$clog2(FLIT_BYTES)-1:0] flit_byte_idx_t;
  typedef logic [7:0]                    node_id_t;
  typedef logic [15:0]                   checksum_t;

  localparam node_id_t BROADCAST_NODE_ID = 8'hFF;

  typedef enum logic [7:0] {
    NOPE   = 8'h00,
    HEAD   = 8'h01,
    BODY   = 8'h02,
    TAIL   = 8'h03,
    SINGLE = 8'h04
  } flittype_t;

  // Header occupies bytes 0..5 of the wire order; dst_id is byte 5.
  typedef struct packed {
    logic [7:0] vc_id;
    flittype_t  flittype;
    logic [7:0] seq;
    node_id_t   src_id;
    logic [7:0] rsvd;
    node_id_t   dst_id;
  } header_t;

  typedef struct packed {
    header_t    header;
    logic [63:0] payload;
    checksum_t  checksum;
  } flit_t;

  typedef enum logic [31:0] {
    NO_ERROR            = 32'h0,
    RX_BUFFER_OVERFLOW  = 32'h1,
    TX_NOT_REACHABLE    = 32'h2,
    GENERAL_FATAL_ERROR = 32'h3
  } signal_t;

  typedef enum logic {COLLECT, CHECK} rx_state_t;

  // One's complement of the 16-bit sum of words w6..w0 (flit[127:16]).
  function automatic checksum_t calc_checksum(input flit_t f);
    checksum_t s;
    s = '0;
    for (int i = 0; i < 7; i++) s = s + f[31+16*i -: 16];
    return ~s;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/flit_checksum_check.sv
// Combinational flit checksum compare; generation side lives in calc_checksum.
module flit_checksum_check
  import types::*;
(
  input  flit_t flit,
  output logic  ok
);
  assign ok = (calc_checksum(flit) == flit.checksum);
endmodule

// File: rtl/flit_rx_assembler.sv
// UART byte stream -> 128-bit flit, with checksum/dst filtering and overflow reporting.
// Define FLIT_RX_ERR_CNT_EN to add saturating crc/drop/timeout counters.
module flit_rx_assembler
  import types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 34720,
  parameter node_id_t    BROADCAST_ID   = BROADCAST_NODE_ID
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  node_id_t   my_id,
  output flit_t      flit_out,
  output logic       flit_valid,
  input  logic       flit_ready,
  output signal_t    error,
  output logic       busy
`ifdef FLIT_RX_ERR_CNT_EN
  ,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] timeout_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  rx_state_t             state;
  flit_byte_idx_t        cnt;
  logic [TW-1:0]         to_cnt;
  logic [FLIT_WIDTH-1:0] asm_q;
  flit_t                 chk_q;
  logic                  crc_ok, accept, expire, last_byte;

  flit_checksum_check u_chk (.flit(chk_q), .ok(crc_ok));

  assign last_byte = byte_valid && (cnt == flit_byte_idx_t'(FLIT_BYTES-1));
  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire    = (cnt != '0) && !byte_valid && (to_cnt == TW'(TIMEOUT_CYCLES-1));
  assign accept    = crc_ok && (chk_q.header.flittype != NOPE) &&
                     ((chk_q.header.dst_id == my_id) || (chk_q.header.dst_id == BROADCAST_ID));
  assign busy      = (cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      cnt        <= '0;
      to_cnt     <= '0;
      asm_q      <= '0;
      chk_q      <= '0;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      error      <= NO_ERROR;
    end else begin
      error <= NO_ERROR;
      if (flit_valid && flit_ready) flit_valid <= 1'b0;

      if (state == CHECK) begin
        state <= COLLECT;
        if (accept) begin
          if (!flit_valid || flit_ready) begin
            flit_out   <= chk_q;
            flit_valid <= 1'b1;
          end else begin
            error <= RX_BUFFER_OVERFLOW;
          end
        end
      end

      if (byte_valid) begin
        asm_q  <= {asm_q[FLIT_WIDTH-9:0], byte_data};
        cnt    <= cnt + 1'b1;
        to_cnt <= '0;
        // Snapshot into the check register so the next flit can start immediately.
        if (last_byte) begin
          chk_q <= {asm_q[FLIT_WIDTH-9:0], byte_data};
          state <= CHECK;
        end
      end else if (expire) begin
        cnt    <= '0;
        to_cnt <= '0;
      end else if (cnt != '0) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

`ifdef FLIT_RX_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_err_cnt <= '0;
      drop_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (state == CHECK && !crc_ok) crc_err_cnt <= sat_inc(crc_err_cnt);
      if (state == CHECK && accept && flit_valid && !flit_ready) drop_cnt <= sat_inc(drop_cnt);
      if (expire) timeout_cnt <= sat_inc(timeout_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_flit_rx_assembler.sv
// Directed bench for flit_rx_assembler; covers optional counters when FLIT_RX_ERR_CNT_EN is defined.
module tb_flit_rx_assembler;
  import types::*;

  localparam int unsigned TO = 34720;

  localparam logic [127:0] F_A    = 128'h000102030405060708090A0B0C0DD5CE;
  localparam logic [127:0] F_BAD  = 128'h000102030405060708090A0B0C0DD5CF;
  localparam logic [127:0] F_D7   = 128'h000102030407060708090A0B0C0DD5CC;
  localparam logic [127:0] F_BC   = 128'h0001020304FF060708090A0B0C0DD4D4;
  localparam logic [127:0] F_NOPE = 128'h000002030405060708090A0B0C0DD5CF;

  logic       clk = 1'b0;
  logic       rst, byte_valid, flit_ready;
  logic [7:0] byte_data;
  node_id_t   my_id;
  flit_t      flit_out;
  logic       flit_valid, busy;
  signal_t    error;
`ifdef FLIT_RX_ERR_CNT_EN
  logic [15:0] crc_err_cnt, drop_cnt, timeout_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  flit_rx_assembler #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data), .my_id(my_id),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .error(error), .busy(busy)
`ifdef FLIT_RX_ERR_CNT_EN
    , .crc_err_cnt(crc_err_cnt), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with byte_valid low.
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_flit(input logic [127:0] f);
    for (int i = 0; i < 16; i++) send_byte(f[127-8*i -: 8]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; byte_valid = 1'b0; byte_data = '0; my_id = 8'h05; flit_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_flit_out", flit_out, '0);
    chk("rst_valid", flit_valid, 1'b0);
    chk("rst_error", error, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic flit, latency N+2 and single-cycle valid with ready=1
    send_flit(F_A);
    chk("basic_n1_valid", flit_valid, 1'b0);
    chk("basic_busy", busy, 1'b0);
    @(negedge clk);
    chk("basic_valid", flit_valid, 1'b1);
    chk("basic_flit", flit_out, F_A);
    @(negedge clk);
    chk("basic_pulse_end", flit_valid, 1'b0);

    // Corrupted checksum
    send_flit(F_BAD);
    @(negedge clk);
    chk("crc_valid", flit_valid, 1'b0);
    chk("crc_error", error, 32'h0);
`ifdef FLIT_RX_ERR_CNT_EN
    chk("crc_cnt", crc_err_cnt, 16'd1);
`endif

    // Destination filtering
    send_flit(F_D7);
    @(negedge clk);
    chk("dst7_valid", flit_valid, 1'b0);
    send_flit(F_BC);
    @(negedge clk);
    chk("bcast_valid", flit_valid, 1'b1);
    chk("bcast_flit", flit_out, F_BC);
    @(negedge clk);
    send_flit(F_NOPE);
    @(negedge clk);
    chk("nope_valid", flit_valid, 1'b0);

    // Back-to-back with ready low: second flit overflows
    flit_ready = 1'b0;
    send_flit(F_A);
    send_flit(F_BC);
    chk("ovf_pre_error", error, 32'h0);
    chk("ovf_pre_valid", flit_valid, 1'b1);
    @(negedge clk);
    chk("ovf_error", error, 32'h1);
    chk("ovf_hold_flit", flit_out, F_A);
    chk("ovf_hold_valid", flit_valid, 1'b1);
    @(negedge clk);
    chk("ovf_error_pulse", error, 32'h0);
    chk("ovf_hold_flit2", flit_out, F_A);
`ifdef FLIT_RX_ERR_CNT_EN
    chk("ovf_drop_cnt", drop_cnt, 16'd1);
    chk("ovf_crc_cnt", crc_err_cnt, 16'd1);
`endif
    flit_ready = 1'b1;
    @(negedge clk);
    chk("ovf_drain", flit_valid, 1'b0);

    // Partial flit timeout, then realignment
    for (int i = 0; i < 7; i++) send_byte(F_A[127-8*i -: 8]);
    chk("to_busy_start", busy, 1'b1);
    repeat (TO - 10) @(negedge clk);
    chk("to_busy_before", busy, 1'b1);
    repeat (20) @(negedge clk);
    chk("to_busy_after", busy, 1'b0);
    chk("to_error", error, 32'h0);
`ifdef FLIT_RX_ERR_CNT_EN
    chk("to_cnt", timeout_cnt, 16'd1);
`endif
    send_flit(F_A);
    @(negedge clk);
    chk("to_realign_valid", flit_valid, 1'b1);
    chk("to_realign_flit", flit_out, F_A);
    @(negedge clk);

    // Reset mid-flit with a pending output flit
    flit_ready = 1'b0;
    send_flit(F_BC);
    @(negedge clk);
    chk("mrst_pending", flit_valid, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(F_A[127-8*i -: 8]);
    chk("mrst_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_valid", flit_valid, 1'b0);
    chk("mrst_flit", flit_out, '0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_error", error, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    flit_ready = 1'b1;
    @(negedge clk);
    send_flit(F_D7 ^ F_D7 ^ F_A);
    @(negedge clk);
    chk("mrst_after_valid", flit_valid, 1'b1);
    chk("mrst_after_flit", flit_out, F_A);
`ifdef FLIT_RX_ERR_CNT_EN
    chk("mrst_cnt_clear", {crc_err_cnt, drop_cnt, timeout_cnt}, '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
